// File: rtl/mux_sel_sequencer.sv
// Steps a 4-input mux through its select codes, samples each, returns a 4-bit result.
// Optional MUX_SEQ_PARITY_EN adds a registered res_parity output.
module mux_sel_sequencer #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       abort,
  output logic       sel1,
  output logic       sel2,
  input  logic       mux_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
`ifdef MUX_SEQ_PARITY_EN
  output logic       res_parity,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

  state_t           state_q, state_n;
  logic [1:0]       code_q, code_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [3:0]       data_q, data_n;
  logic             valid_q, valid_n;
  logic             rdy_q, rdy_n;
  logic             busy_q, busy_n;
`ifdef MUX_SEQ_PARITY_EN
  logic             par_q, par_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= 2'd0;
      cnt_q   <= '0;
      data_q  <= 4'd0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef MUX_SEQ_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      code_q  <= code_n;
      cnt_q   <= cnt_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      rdy_q   <= rdy_n;
      busy_q  <= busy_n;
`ifdef MUX_SEQ_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    code_n  = code_q;
    cnt_n   = cnt_q;
    data_n  = data_q;
    valid_n = valid_q;
`ifdef MUX_SEQ_PARITY_EN
    par_n   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_n = DRIVE;
          code_n  = 2'd0;
          cnt_n   = '0;
          data_n  = 4'd0;
        end
      end
      DRIVE: begin
        cnt_n = cnt_q + 1'b1;
        if (abort) begin
          state_n = IDLE;
          code_n  = 2'd0;
          cnt_n   = '0;
        end else if (cnt_q == LAST) begin
          state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        // abort beats the sample write
        if (abort) begin
          state_n = IDLE;
          code_n  = 2'd0;
          cnt_n   = '0;
        end else begin
          data_n[code_q] = mux_out;
          if (code_q == 2'd3) begin
            state_n = DONE;
            valid_n = 1'b1;
`ifdef MUX_SEQ_PARITY_EN
            par_n   = ^{mux_out, data_q[2:0]};
`endif
          end else begin
            state_n = DRIVE;
            code_n  = code_q + 2'd1;
            cnt_n   = '0;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_n = IDLE;
          valid_n = 1'b0;
          code_n  = 2'd0;
        end
      end
      default: state_n = IDLE;
    endcase
    rdy_n  = (state_n == IDLE);
    busy_n = (state_n != IDLE);
  end

  assign sel1        = code_q[0];
  assign sel2        = code_q[1];
  assign start_ready = rdy_q;
  assign busy        = busy_q;
  assign res_valid   = valid_q;
  assign res_data    = data_q;
`ifdef MUX_SEQ_PARITY_EN
  assign res_parity  = par_q;
`endif

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: timeline model plus directed scans.
// Build with MUX_SEQ_PARITY_EN to also cover res_parity.
module tb_mux_sel_sequencer;

  localparam int S   = 2;
  localparam int P   = S + 1;
  localparam int LAT = 4 * P;

  logic       clk;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic       abort;
  logic       sel1;
  logic       sel2;
  logic       mux_out;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       busy;
  logic [3:0] pat;
`ifdef MUX_SEQ_PARITY_EN
  logic       res_parity;
`endif

  mux_sel_sequencer #(.SETTLE(S), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .abort(abort),
    .sel1(sel1),
    .sel2(sel2),
    .mux_out(mux_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
`ifdef MUX_SEQ_PARITY_EN
    .res_parity(res_parity),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mux_out = pat[{sel2, sel1}];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_ph = edges since the accepting edge (-1 idle, LAT = result held)
  int         m_ph;
  logic [3:0] m_data;
  logic       m_par;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph   <= -1;
      m_data <= 4'd0;
      m_par  <= 1'b0;
    end else if (m_ph < 0) begin
      if (start_valid) begin
        m_ph   <= 0;
        m_data <= 4'd0;
      end
    end else if (m_ph < LAT) begin
      if (abort) begin
        m_ph <= -1;
      end else begin
        m_ph <= m_ph + 1;
        if ((m_ph + 1) % P == 0)
          m_data[(m_ph + 1) / P - 1] <= mux_out;
      end
    end else if (res_ready) begin
      m_ph  <= -1;
      m_par <= ^m_data;
    end
  end

  function automatic int exp_code();
    if (m_ph < 0)    return 0;
    if (m_ph >= LAT) return 3;
    return m_ph / P;
  endfunction

  always @(negedge clk) begin
    check("start_ready", start_ready, m_ph < 0);
    check("busy", busy, m_ph >= 0);
    check("sel", {sel2, sel1}, exp_code());
    check("res_valid", res_valid, m_ph == LAT);
    check("res_data", res_data, m_data);
`ifdef MUX_SEQ_PARITY_EN
    check("res_parity", res_parity, (m_ph == LAT) ? ^m_data : m_par);
`endif
  end

  int lat;
  int sel_at[0:LAT];
  logic b[0:41];

  // pulse start, record selects after each edge, return edges to res_valid
  task automatic run_scan(output int k);
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    sel_at[0] = {sel2, sel1};
    k = 0;
    while (!res_valid && k < 40) begin
      @(negedge clk);
      k++;
      if (k <= LAT) sel_at[k] = {sel2, sel1};
    end
  endtask

  initial begin
    int hi_runs[$];
    int lo_runs[$];
    int run;
    rst_n       = 1'b1;
    start_valid = 1'b0;
    abort       = 1'b0;
    res_ready   = 1'b0;
    pat         = 4'b1010;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_start_ready", start_ready, 1);
    check("rst_sel", {sel2, sel1}, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_scan(lat);
    check("scan1_latency", lat, 12);
    check("scan1_sel_k2", sel_at[2], 0);
    check("scan1_sel_k3", sel_at[3], 1);
    check("scan1_sel_k8", sel_at[8], 2);
    check("scan1_sel_k9", sel_at[9], 3);
    check("scan1_data", res_data, 4'b1010);
`ifdef MUX_SEQ_PARITY_EN
    check("scan1_parity", res_parity, 0);
`endif

    start_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_held", res_valid, 1);
      check("bp_data_held", res_data, 4'b1010);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_idle_ready", start_ready, 1);
    check("bp_valid_low", res_valid, 0);
    check("bp_sel_home", {sel2, sel1}, 0);

    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("ab_in_code2", {sel2, sel1}, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_idle", start_ready, 1);
    check("ab_sel", {sel2, sel1}, 0);
    check("ab_partial", res_data, 4'b0010);
    repeat (20) begin
      @(negedge clk);
      check("ab_no_result", res_valid, 0);
    end

    pat = 4'b0111;
    run_scan(lat);
    check("scan2_latency", lat, 12);
    check("scan2_data", res_data, 4'b0111);
`ifdef MUX_SEQ_PARITY_EN
    check("scan2_parity", res_parity, 1);
`endif
    res_ready = 1'b1;
    @(negedge clk);

    pat         = 4'b1100;
    start_valid = 1'b1;
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      b[i] = busy;
    end
    start_valid = 1'b0;
    run = 1;
    for (int i = 1; i < 42; i++) begin
      if (b[i] == b[i-1]) begin
        run++;
      end else begin
        if (b[i-1]) hi_runs.push_back(run);
        else        lo_runs.push_back(run);
        run = 1;
      end
    end
    check("b2b_scans", hi_runs.size(), 3);
    check("b2b_gaps", lo_runs.size(), 2);
    check("b2b_busy_len0", hi_runs.size() > 0 ? hi_runs[0] : 0, 13);
    check("b2b_busy_len1", hi_runs.size() > 1 ? hi_runs[1] : 0, 13);
    check("b2b_gap0", lo_runs.size() > 0 ? lo_runs[0] : 0, 1);
    check("b2b_data", res_data, 4'b1100);
    repeat (3) @(negedge clk);
    res_ready = 1'b0;

    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("ar_in_code1", {sel2, sel1}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_sel", {sel2, sel1}, 0);
    check("ar_busy", busy, 0);
    check("ar_ready", start_ready, 1);
    check("ar_valid", res_valid, 0);
    check("ar_data", res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
